// File: rtl/sync_accum_align.sv
// sync_accum_align: carries the multiplier tag alongside an external
// accumulator through a programmable delay line and realigns it with the
// accumulator result. Also flags valid misalignment between the two paths.
module sync_accum_align #(
  parameter int DATA_W    = 24,
  parameter int TAG_W     = 1,
  parameter int MAX_DEPTH = 8,
  parameter int CNT_W     = 8,
  localparam int LAT_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    err_clear,
  input  logic [LAT_W-1:0]        lat_sel,
  input  logic                    mult_in_valid,
  input  logic [DATA_W+TAG_W-1:0] mult_output,
  output logic [DATA_W-1:0]       accum_input,
  output logic                    accum_in_valid,
  input  logic [DATA_W-1:0]       accum_output,
  input  logic                    accum_out_valid,
  output logic [DATA_W+TAG_W-1:0] accum_output_full,
  output logic                    out_valid,
  output logic [LAT_W-1:0]        in_flight,
  output logic                    align_err,
  output logic [CNT_W-1:0]        err_count
);

  localparam logic [LAT_W-1:0] MAX_L = LAT_W'(MAX_DEPTH);
  localparam logic [LAT_W-1:0] ONE_L = LAT_W'(1);

  logic [MAX_DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [MAX_DEPTH];
  logic [TAG_W-1:0]     tag_d [MAX_DEPTH];
  logic [LAT_W-1:0]     lat_sel_q;
  logic                 align_err_q, align_err_d;
  logic [CNT_W-1:0]     err_count_q, err_count_d;

  logic [LAT_W-1:0]     lat_eff;
  logic                 tap_valid;
  logic [TAG_W-1:0]     tap_tag;
  logic                 mismatch;
  logic                 lat_chg;

  // Data path to the accumulator is purely combinational.
  always_comb begin
    accum_input    = mult_output[DATA_W-1:0];
    accum_in_valid = mult_in_valid & en & ~flush;
  end

  // Clamp the registered latency select to 1..MAX_DEPTH.
  always_comb begin
    lat_eff = lat_sel_q;
    if (lat_sel_q == '0)
      lat_eff = ONE_L;
    else if (lat_sel_q > MAX_L)
      lat_eff = MAX_L;
  end

  // Tap mux (stage L-1) and valid count over the active window.
  always_comb begin
    tap_valid = 1'b0;
    tap_tag   = '0;
    in_flight = '0;
    for (int unsigned k = 0; k < MAX_DEPTH; k++) begin
      if (LAT_W'(k) == lat_eff - ONE_L) begin
        tap_valid = valid_q[k];
        tap_tag   = tag_q[k];
      end
      if ((LAT_W'(k) < lat_eff) && valid_q[k])
        in_flight = in_flight + ONE_L;
    end
  end

  always_comb begin
    out_valid         = tap_valid;
    accum_output_full = {tap_tag, accum_output};
    align_err         = align_err_q;
    err_count         = err_count_q;
  end

  // Delay-line next state: flush beats advance, en=0 holds.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (flush) begin
      valid_d = '0;
      for (int unsigned k = 0; k < MAX_DEPTH; k++) tag_d[k] = '0;
    end else if (en) begin
      valid_d[0] = mult_in_valid;
      tag_d[0]   = mult_output[DATA_W+TAG_W-1 -: TAG_W];
      for (int unsigned k = 1; k < MAX_DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        tag_d[k]   = tag_q[k-1];
      end
    end
  end

  // Error tracking: valid mismatch counts, latency change only flags.
  always_comb begin
    mismatch    = en & ~flush & (accum_out_valid != tap_valid);
    lat_chg     = (lat_sel != lat_sel_q) && (in_flight != '0);
    align_err_d = align_err_q;
    err_count_d = err_count_q;
    if (err_clear) begin
      align_err_d = 1'b0;
      err_count_d = '0;
    end else begin
      if (mismatch) begin
        align_err_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
      end
      if (lat_chg) align_err_d = 1'b1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      for (int unsigned k = 0; k < MAX_DEPTH; k++) tag_q[k] <= '0;
      lat_sel_q   <= '0;
      align_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      valid_q     <= valid_d;
      for (int unsigned k = 0; k < MAX_DEPTH; k++) tag_q[k] <= tag_d[k];
      lat_sel_q   <= lat_sel;
      align_err_q <= align_err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_sync_accum_align.sv
// Scoreboard bench for sync_accum_align: stimulus queues expected tap words
// with the cycle they must appear; a monitor pops them as the tap advances.
module tb_sync_accum_align;

  localparam int DW = 8;
  localparam int TW = 1;
  localparam int MD = 8;
  localparam int CW = 2;
  localparam int LW = $clog2(MD + 1);

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           en = 1'b1, flush = 1'b0, err_clear = 1'b0;
  logic [LW-1:0]  lat_sel = '0;
  logic           mult_in_valid = 1'b0;
  logic [DW+TW-1:0] mult_output = '0;
  logic [DW-1:0]  accum_input;
  logic           accum_in_valid;
  logic [DW-1:0]  accum_output = 8'h5A;
  logic           accum_out_valid;
  logic [DW+TW-1:0] accum_output_full;
  logic           out_valid;
  logic [LW-1:0]  in_flight;
  logic           align_err;
  logic [CW-1:0]  err_count;

  logic mirror = 1'b1, aov_force = 1'b0;
  assign accum_out_valid = mirror ? out_valid : aov_force;

  sync_accum_align #(.DATA_W(DW), .TAG_W(TW), .MAX_DEPTH(MD), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .en(en), .flush(flush),
    .err_clear(err_clear), .lat_sel(lat_sel), .mult_in_valid(mult_in_valid),
    .mult_output(mult_output), .accum_input(accum_input),
    .accum_in_valid(accum_in_valid), .accum_output(accum_output),
    .accum_out_valid(accum_out_valid), .accum_output_full(accum_output_full),
    .out_valid(out_valid), .in_flight(in_flight), .align_err(align_err),
    .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW+TW-1:0] word;
    int unsigned      cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  logic        adv = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    adv <= en & ~flush;
  end

  // Monitor: a valid tap just loaded by an advancing edge is one output word.
  always @(negedge clock) begin
    if (reset_n && out_valid && adv) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word got=%h at cycle %0d, expected none", accum_output_full, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (accum_output_full !== e.word) begin
          n_err++;
          $display("FAIL tap_word got=%h expected=%h", accum_output_full, e.word);
        end
        n_cmp++;
        if (cyc != e.cyc) begin
          n_err++;
          $display("FAIL tap_cycle got=%0d expected=%0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    mult_in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Present one word; if tracked, expect it at the tap 'off' edges later.
  task automatic push(input logic tag, input logic [DW-1:0] d, input int off, input bit track);
    exp_t e;
    mult_in_valid = 1'b1;
    mult_output   = {tag, d};
    #1;
    chk("accum_input", int'(accum_input), int'(d));
    chk("accum_in_valid", int'(accum_in_valid), int'(en & ~flush));
    if (track) begin
      e.word = {tag, accum_output};
      e.cyc  = cyc + 1 + off;
      sb.push_back(e);
    end
    step();
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_flight", int'(in_flight), 0);
    chk("rst_align_err", int'(align_err), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_tag", int'(accum_output_full[DW]), 0);
    reset_n = 1'b1;

    // Legacy 4-cycle delay, tags 1,0,1, mirrored accumulator valid
    lat_sel = 4'd4;
    idle(1);
    push(1'b1, 8'h11, 3, 1);
    push(1'b0, 8'h22, 3, 1);
    push(1'b1, 8'h33, 3, 1);
    idle(9);
    chk("l4_align_err", int'(align_err), 0);

    // Clamping: 0 -> 1 cycle, 15 -> 8 cycles
    lat_sel = 4'd0;
    idle(1);
    push(1'b1, 8'h44, 0, 1);
    idle(9);
    lat_sel = 4'd15;
    idle(1);
    push(1'b0, 8'h55, 7, 1);
    idle(10);
    chk("clamp_align_err", int'(align_err), 0);

    // Hold with en=0 for 5 cycles while three words are in flight
    accum_output = 8'hC3;
    lat_sel = 4'd4;
    idle(1);
    push(1'b1, 8'h01, 3, 1);
    push(1'b0, 8'h02, 8, 1);
    push(1'b1, 8'h03, 8, 1);
    idle(1);
    en = 1'b0;
    mult_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_accum_in_valid", int'(accum_in_valid), 0);
      step();
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_tag", int'(accum_output_full[DW]), 1);
      chk("hold_in_flight", int'(in_flight), 3);
    end
    mult_in_valid = 1'b0;
    en = 1'b1;
    idle(9);

    // Flush three in-flight words; no error with accumulator valid low
    mirror = 1'b0;
    aov_force = 1'b0;
    push(1'b1, 8'h0A, 0, 0);
    push(1'b1, 8'h0B, 0, 0);
    push(1'b1, 8'h0C, 0, 0);
    chk("pre_flush_in_flight", int'(in_flight), 3);
    flush = 1'b1;
    mult_in_valid = 1'b1;
    #1;
    chk("flush_accum_in_valid", int'(accum_in_valid), 0);
    step();
    flush = 1'b0;
    mult_in_valid = 1'b0;
    chk("flush_in_flight", int'(in_flight), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    idle(6);
    chk("flush_align_err", int'(align_err), 0);

    // Saturating error count with CNT_W=2, then clear
    aov_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("err_count_sat", int'(err_count), (i < 3) ? i + 1 : 3);
    end
    chk("err_set", int'(align_err), 1);
    aov_force = 1'b0;
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("clr_align_err", int'(align_err), 0);
    chk("clr_err_count", int'(err_count), 0);

    // Latency change 4->6 with two words in flight
    mirror = 1'b1;
    push(1'b1, 8'h61, 5, 1);
    push(1'b0, 8'h62, 5, 1);
    mult_in_valid = 1'b0;
    chk("latchg_in_flight", int'(in_flight), 2);
    lat_sel = 4'd6;
    step();
    chk("latchg_align_err", int'(align_err), 1);
    chk("latchg_err_count", int'(err_count), 0);
    idle(6);

    // Reset mid-stream while a tagged word sits at the tap
    push(1'b1, 8'h71, 5, 1);
    push(1'b1, 8'h72, 0, 0);
    idle(4);
    @(negedge clock);
    chk("pre_rst_out_valid", int'(out_valid), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_flight", int'(in_flight), 0);
    chk("mid_rst_align_err", int'(align_err), 0);
    chk("mid_rst_tag", int'(accum_output_full[DW]), 0);
    step();
    reset_n = 1'b1;
    idle(10);
    chk("post_rst_align_err", int'(align_err), 0);
    chk("post_rst_err_count", int'(err_count), 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
